// File: rtl/serial_adder.sv
// Multi-cycle adder/subtractor: processes CHUNK bits per clock with a registered
// carry, under a start/busy/done handshake. WIDTH=1, CHUNK=1 is a plain full adder.
module serial_adder #(
   parameter int WIDTH = 8,
   parameter int CHUNK = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             sub,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             c_in,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             c_out,
   output logic             ovf
);

   localparam int N  = WIDTH / CHUNK;
   localparam int CW = (N > 1) ? $clog2(N) : 1;
   localparam logic [CW-1:0] LAST = CW'(N - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state, state_nxt;
   logic [WIDTH-1:0] a_sh, b_sh, psum, psum_nxt;
   logic             carry;
   logic [CW-1:0]    cnt;
   logic [CHUNK:0]   chunk_sum;
   logic             msb_cin;
   logic             last;
   logic             accept;

   // Chunk adder and the partial sum as it will look after this chunk is shifted in
   always_comb begin
      chunk_sum = {1'b0, a_sh[CHUNK-1:0]} + {1'b0, b_sh[CHUNK-1:0]}
                + {{CHUNK{1'b0}}, carry};
      msb_cin   = a_sh[CHUNK-1] ^ b_sh[CHUNK-1] ^ chunk_sum[CHUNK-1];
      psum_nxt  = psum >> CHUNK;
      psum_nxt[WIDTH-1 -: CHUNK] = chunk_sum[CHUNK-1:0];
      last      = (cnt == LAST);
      accept    = start && ((state == IDLE) || (state == DONE));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    state_nxt = start ? RUN : IDLE;
         RUN:     state_nxt = last ? DONE : RUN;
         DONE:    state_nxt = start ? RUN : IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      busy = (state == RUN);
      done = (state == DONE);
   end

   // Result registers load only on the final chunk so partial sums never show
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_sh  <= '0;
         b_sh  <= '0;
         psum  <= '0;
         carry <= 1'b0;
         cnt   <= '0;
         sum   <= '0;
         c_out <= 1'b0;
         ovf   <= 1'b0;
      end else if (accept) begin
         a_sh  <= a;
         b_sh  <= sub ? ~b : b;
         carry <= sub ? 1'b1 : c_in;
         cnt   <= '0;
         psum  <= '0;
      end else if (state == RUN) begin
         a_sh  <= a_sh >> CHUNK;
         b_sh  <= b_sh >> CHUNK;
         psum  <= psum_nxt;
         carry <= chunk_sum[CHUNK];
         cnt   <= cnt + CW'(1);
         if (last) begin
            sum   <= psum_nxt;
            c_out <= chunk_sum[CHUNK];
            ovf   <= msb_cin ^ chunk_sum[CHUNK];
         end
      end
   end

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: three instances (1/1, 8/1, 16/4) checked against a
// full-width arithmetic model through an expected-result queue.
module tb_serial_adder;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        start[3];
   logic        sub[3];
   logic        cin[3];
   logic [15:0] a[3];
   logic [15:0] b[3];

   logic        busy1, done1, cout1, ovf1;
   logic [0:0]  sum1;
   logic        busy8, done8, cout8, ovf8;
   logic [7:0]  sum8;
   logic        busy16, done16, cout16, ovf16;
   logic [15:0] sum16;

   serial_adder #(.WIDTH(1), .CHUNK(1)) dut1 (
      .clk(clk), .rst(rst), .start(start[0]), .sub(sub[0]), .a(a[0][0:0]), .b(b[0][0:0]),
      .c_in(cin[0]), .busy(busy1), .done(done1), .sum(sum1), .c_out(cout1), .ovf(ovf1));

   serial_adder #(.WIDTH(8), .CHUNK(1)) dut8 (
      .clk(clk), .rst(rst), .start(start[1]), .sub(sub[1]), .a(a[1][7:0]), .b(b[1][7:0]),
      .c_in(cin[1]), .busy(busy8), .done(done8), .sum(sum8), .c_out(cout8), .ovf(ovf8));

   serial_adder #(.WIDTH(16), .CHUNK(4)) dut16 (
      .clk(clk), .rst(rst), .start(start[2]), .sub(sub[2]), .a(a[2]), .b(b[2]),
      .c_in(cin[2]), .busy(busy16), .done(done16), .sum(sum16), .c_out(cout16), .ovf(ovf16));

   typedef struct packed {
      logic [15:0] sum;
      logic        c;
      logic        v;
   } exp_t;

   exp_t        q[$];
   int          sel = 0;
   int          total = 0;
   int          bad = 0;
   int          width_of[3] = '{1, 8, 16};
   logic [15:0] hold_sum[3];
   logic        hold_c[3];
   logic        hold_v[3];

   logic        o_busy, o_done, o_c, o_v;
   logic [15:0] o_sum;

   always_comb begin
      o_busy = busy16; o_done = done16; o_sum = sum16; o_c = cout16; o_v = ovf16;
      case (sel)
         0: begin o_busy = busy1; o_done = done1; o_sum = {15'b0, sum1}; o_c = cout1; o_v = ovf1; end
         1: begin o_busy = busy8; o_done = done8; o_sum = {8'b0, sum8};  o_c = cout8; o_v = ovf8; end
         default: ;
      endcase
   end

   function automatic exp_t model(input int w, input logic [15:0] x, input logic [15:0] y,
                                  input logic s, input logic ci);
      logic [16:0] mask, r;
      logic [15:0] xx, bb;
      exp_t e;
      mask  = (17'd1 << w) - 17'd1;
      xx    = x & mask[15:0];
      bb    = (s ? ~y : y) & mask[15:0];
      r     = {1'b0, xx} + {1'b0, bb} + {16'b0, (s ? 1'b1 : ci)};
      e.sum = r[15:0] & mask[15:0];
      e.c   = r[w];
      e.v   = (xx[w-1] == bb[w-1]) && (e.sum[w-1] != xx[w-1]);
      return e;
   endfunction

   task automatic clear_holds();
      for (int i = 0; i < 3; i++) begin
         hold_sum[i] = '0; hold_c[i] = 1'b0; hold_v[i] = 1'b0;
      end
   endtask

   task automatic launch(input logic [15:0] x, input logic [15:0] y, input logic s, input logic ci);
      a[sel] = x; b[sel] = y; sub[sel] = s; cin[sel] = ci; start[sel] = 1'b1;
      q.push_back(model(width_of[sel], x, y, s, ci));
      @(posedge clk); #1;
      start[sel] = 1'b0;
      a[sel] = 16'($urandom); b[sel] = 16'($urandom); sub[sel] = ~s; cin[sel] = ~ci;
   endtask

   task automatic wait_result(input int exp_k, input string name);
      int   k = 0;
      exp_t e;
      while (o_done !== 1'b1 && k < 40) begin
         total++;
         if (o_busy !== 1'b1) begin
            bad++; $display("FAIL %s busy k=%0d got=%b want=1", name, k, o_busy);
         end
         total++;
         if ({o_sum, o_c, o_v} !== {hold_sum[sel], hold_c[sel], hold_v[sel]}) begin
            bad++;
            $display("FAIL %s held_result k=%0d got=%h/%b/%b want=%h/%b/%b", name, k,
                     o_sum, o_c, o_v, hold_sum[sel], hold_c[sel], hold_v[sel]);
         end
         @(posedge clk); #1;
         k++;
      end
      total++;
      if (k != exp_k) begin
         bad++; $display("FAIL %s latency got=%0d want=%0d", name, k, exp_k);
      end
      total++;
      if (o_busy !== 1'b0) begin
         bad++; $display("FAIL %s busy_with_done got=%b want=0", name, o_busy);
      end
      total++;
      if (q.size() == 0) begin
         bad++; $display("FAIL %s scoreboard_empty got=0 want>0", name);
      end else begin
         e = q.pop_front();
         if ({o_sum, o_c, o_v} !== {e.sum, e.c, e.v}) begin
            bad++;
            $display("FAIL %s result got sum=%h c=%b v=%b want sum=%h c=%b v=%b",
                     name, o_sum, o_c, o_v, e.sum, e.c, e.v);
         end
         hold_sum[sel] = e.sum; hold_c[sel] = e.c; hold_v[sel] = e.v;
      end
   endtask

   task automatic test_reset();
      #1 rst = 1'b1;
      #1;
      total++;
      if ({busy1, done1, sum1, cout1, ovf1} !== 5'b0) begin
         bad++; $display("FAIL reset_w1 got=%b want=0", {busy1, done1, sum1, cout1, ovf1});
      end
      total++;
      if ({busy8, done8, sum8, cout8, ovf8} !== 12'b0) begin
         bad++; $display("FAIL reset_w8 got=%h want=0", {busy8, done8, sum8, cout8, ovf8});
      end
      total++;
      if ({busy16, done16, sum16, cout16, ovf16} !== 20'b0) begin
         bad++; $display("FAIL reset_w16 got=%h want=0", {busy16, done16, sum16, cout16, ovf16});
      end
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic test_full_adder();
      sel = 0;
      for (int i = 0; i < 8; i++) begin
         launch(16'(i[1]), 16'(i[0]), 1'b0, i[2]);
         wait_result(1, "full_adder");
      end
   endtask

   task automatic test_add8();
      sel = 1;
      launch(16'h5A, 16'h33, 1'b0, 1'b0); wait_result(8, "add_5a_33");
      launch(16'hFF, 16'h01, 1'b0, 1'b0); wait_result(8, "add_ff_01");
      for (int i = 0; i < 4; i++) begin
         launch(16'($urandom_range(0, 255)), 16'($urandom_range(0, 255)), 1'b0, 1'($urandom));
         wait_result(8, "add_rand");
      end
   endtask

   task automatic test_sub8();
      sel = 1;
      launch(16'h10, 16'h20, 1'b1, 1'b0); wait_result(8, "sub_10_20");
      launch(16'h10, 16'h20, 1'b1, 1'b1); wait_result(8, "sub_10_20_cin");
      launch(16'h80, 16'h01, 1'b1, 1'b0); wait_result(8, "sub_80_01");
      launch(16'h80, 16'h01, 1'b1, 1'b1); wait_result(8, "sub_80_01_cin");
   endtask

   task automatic test_back_to_back();
      sel = 2;
      a[2] = 16'hFFFF; b[2] = 16'h0000; sub[2] = 1'b0; cin[2] = 1'b1; start[2] = 1'b1;
      q.push_back(model(16, 16'hFFFF, 16'h0000, 1'b0, 1'b1));
      @(posedge clk); #1;
      a[2] = 16'h1234; b[2] = 16'h1111; cin[2] = 1'b0;
      q.push_back(model(16, 16'h1234, 16'h1111, 1'b0, 1'b0));
      wait_result(4, "b2b_first");
      @(posedge clk); #1;
      start[2] = 1'b0;
      wait_result(4, "b2b_second");
      launch(16'($urandom), 16'($urandom), 1'b1, 1'b0); wait_result(4, "w16_sub_rand");
   endtask

   task automatic test_start_in_run();
      sel = 1;
      launch(16'h3C, 16'h0F, 1'b0, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      a[1] = 16'hFF; b[1] = 16'hFF; sub[1] = 1'b1; start[1] = 1'b1;
      @(posedge clk); #1;
      start[1] = 1'b0;
      wait_result(5, "start_in_run");
   endtask

   task automatic test_rst_mid_run();
      bit saw_done = 0;
      sel = 1;
      launch(16'h77, 16'h22, 1'b0, 1'b1);
      repeat (2) @(posedge clk);
      #2 rst = 1'b1;
      #1;
      total++;
      if ({o_busy, o_done, o_sum, o_c, o_v} !== 20'b0) begin
         bad++; $display("FAIL rst_mid_run got=%h want=0", {o_busy, o_done, o_sum, o_c, o_v});
      end
      q.delete();
      clear_holds();
      @(posedge clk); #1;
      rst = 1'b0;
      for (int i = 0; i < 10; i++) begin
         if (o_done !== 1'b0 || o_busy !== 1'b0) saw_done = 1;
         @(posedge clk); #1;
      end
      total++;
      if (saw_done) begin
         bad++; $display("FAIL rst_no_done got=1 want=0");
      end
      launch(16'h01, 16'h01, 1'b0, 1'b0);
      wait_result(8, "after_rst_add");
   endtask

   initial begin
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         start[i] = 1'b0; sub[i] = 1'b0; cin[i] = 1'b0; a[i] = '0; b[i] = '0;
      end
      clear_holds();
      test_reset();
      test_full_adder();
      test_add8();
      test_sub8();
      test_back_to_back();
      test_start_in_run();
      test_rst_mid_run();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/serial_adder.md
# serial_adder

Parametrised multi-cycle adder/subtractor that generalises the single-bit full adder into a WIDTH-bit datapath. Each clock it processes CHUNK bits with a registered carry, under a start/busy/done handshake. Used where a full-width ripple adder is too large, or where operands arrive from slow sequential producers. WIDTH=1, CHUNK=1 reproduces the one-bit full adder with one cycle of handshake latency.

## Interface

Parameters:
- WIDTH, 8, operand and result width in bits; must be ≥ 1.
- CHUNK, 1, bits processed per cycle; must divide WIDTH. N = WIDTH/CHUNK is the number of RUN cycles.

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- rst  in  1  reset, asynchronous and active-high.
- start  in  1  request; sampled only in IDLE or DONE.
- sub  in  1  0 = add, 1 = subtract (a − b); sampled with start.
- a  in  WIDTH  operand A; sampled with start.
- b  in  WIDTH  operand B; sampled with start.
- c_in  in  1  carry-in for add; ignored when sub=1.
- busy  out  1  high during RUN.
- done  out  1  one-cycle pulse; result valid.
- sum  out  WIDTH  result, held until the next done.
- c_out  out  1  carry out of the MSB; for subtract, 1 = no borrow.
- ovf  out  1  two's-complement overflow, computed as carry into MSB XOR carry out of MSB.

## Operation

- FSM states: IDLE, RUN, DONE.
- IDLE, start=1:
  - Latch a into shift register A.
  - Latch b into shift register B, or ~b if sub=1.
  - Carry register ← c_in if sub=0, else 1.
  - Chunk counter ← 0; go to RUN.
- IDLE, start=0: stay in IDLE.
- RUN, each cycle:
  - Add the low CHUNK bits of A and B plus the carry register.
  - Shift A and B right by CHUNK.
  - Shift the CHUNK result bits into the MSB end of the partial-sum register.
  - Update the carry register.
  - Capture the carry into the MSB when the final chunk is processed.
  - Increment the counter. After the N-th chunk, go to DONE.
- Entering DONE: sum, c_out and ovf load from the partial-sum and carry logic. They are not updated at any other time.
- DONE lasts one cycle, with done=1.
  - start=1: accept new operands exactly as in IDLE and go to RUN (back-to-back).
  - start=0: go to IDLE.
- start in RUN is ignored. Operands and sub may change freely after the accepting edge.
- Arithmetic is modulo 2^WIDTH. The {c_out, sum} pair equals a + b + c_in (add) or a + ~b + 1 (sub).

## Timing

- Reset values, applied immediately on rst rising (no clock needed): state IDLE, busy=0, done=0, sum=0, c_out=0, ovf=0; internal registers cleared.
- Latency: start accepted at edge E0. busy=1 from after E0 through the cycle before E_N. done=1 for the single cycle between E_N and E_{N+1}, with busy=0 in that cycle.
- Throughput: one result per N+1 cycles when start is held high.
- sum, c_out and ovf are stable from E_N until the next completion. Partial results are never visible on them.
- rst asserted mid-RUN: the operation is aborted, no done is produced, and outputs return to 0. The first start after rst deasserts behaves normally.
- busy and done are never both high.

## Test plan

- WIDTH=1, CHUNK=1, sub=0, all 8 {c_in,a,b} combinations → {c_out,sum} matches the full-adder truth table (e.g. 1,1,1 → c_out=1, sum=1). done occurs 1 edge after accept.
- WIDTH=8, CHUNK=1, add:
  - a=0x5A, b=0x33, c_in=0 → sum=0x8D, c_out=0, ovf=1; busy high 8 cycles, done at E8.
  - a=0xFF, b=0x01, c_in=0 → sum=0x00, c_out=1, ovf=0.
- WIDTH=8, CHUNK=1, sub:
  - a=0x10, b=0x20 → sum=0xF0, c_out=0, ovf=0.
  - a=0x80, b=0x01 → sum=0x7F, c_out=1, ovf=1.
  - c_in=1 has no effect on either result.
- WIDTH=16, CHUNK=4: a=0xFFFF, b=0x0000, c_in=1 → sum=0x0000, c_out=1, ovf=0, done at E4. Then, with start held high, a second operation a=0x1234, b=0x1111, c_in=0 is accepted in the DONE cycle → sum=0x2345 at E9.
- Control hazards, WIDTH=8, CHUNK=1:
  - start pulsed during RUN with different operands → ignored; the first result completes unchanged.
  - rst at the 3rd RUN cycle → busy, done, sum, c_out and ovf go to 0 asynchronously with no done pulse; a following add of 0x01 + 0x01 gives sum=0x02.
